// File: rtl/data_mem_responder.sv
// Purpose : data-memory responder; services one load/store per transaction from an internal word RAM.
// Latency : request seen in IDLE at cycle T -> rsp_valid_o at cycle T+1+WAIT_CYCLES.
// Backpres: busy_o holds the requester through wait states; stall_i holds the response (HOLD).
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_rd_i,
    input  logic                    req_wr_i,
    input  logic [31:0]             req_addr_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] req_be_i,
    input  logic [2:0]              req_load_op_i,
    input  logic                    stall_i,
    output logic                    busy_o,
    output logic                    rsp_valid_o,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o
);

    localparam int NB = DATA_WIDTH / 8;
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_HOLD} state_t;

    state_t                  r_state, w_next;
    logic [3:0]              r_cnt, w_cnt_next;
    logic                    w_accept;

    logic                    r_rd, r_wr;
    logic [ADDR_WIDTH+1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [NB-1:0]           r_be;
    logic [2:0]              r_op;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_err;
    logic [DATA_WIDTH-1:0]   r_mem [0:(1<<ADDR_WIDTH)-1];

    logic                    w_rd, w_wr;
    logic [ADDR_WIDTH+1:0]   w_addr;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic [NB-1:0]           w_be;
    logic [2:0]              w_op;
    logic [1:0]              w_off;
    logic [ADDR_WIDTH-1:0]   w_idx;
    logic                    w_is_half, w_is_word, w_err;
    logic                    w_enter_resp, w_do_write;
    logic [NB-1:0]           w_lanes;
    logic [DATA_WIDTH-1:0]   w_wshift, w_rword, w_fmt;
    logic                    w_valid;
    logic                    w_unused_addr;

    // Address bits above the RAM's word index alias onto the same words.
    assign w_unused_addr = ^req_addr_i[31:ADDR_WIDTH+2];

    // With zero wait states the RAM is accessed on the accept edge, so take the live request.
    assign w_rd    = (r_state == S_IDLE) ? req_rd_i                     : r_rd;
    assign w_wr    = (r_state == S_IDLE) ? req_wr_i                     : r_wr;
    assign w_addr  = (r_state == S_IDLE) ? req_addr_i[ADDR_WIDTH+1:0]   : r_addr;
    assign w_wdata = (r_state == S_IDLE) ? req_wdata_i                  : r_wdata;
    assign w_be    = (r_state == S_IDLE) ? req_be_i                     : r_be;
    assign w_op    = (r_state == S_IDLE) ? req_load_op_i                : r_op;

    assign w_off    = w_addr[1:0];
    assign w_idx    = w_addr[ADDR_WIDTH+1:2];
    assign w_lanes  = w_be << w_off;
    assign w_wshift = w_wdata << {w_off, 3'b000};
    assign w_rword  = r_mem[w_idx] >> {w_off, 3'b000};

    // Access size comes from the load op for reads and from the byte mask for writes.
    always_comb begin
        w_is_half = 1'b0;
        w_is_word = 1'b0;
        if (w_rd) begin
            w_is_half = (w_op[1:0] == 2'b01);
            w_is_word = (w_op[1:0] == 2'b10);
        end else begin
            w_is_half = (w_be == 4'b0011);
            w_is_word = (w_be == 4'b1111);
        end
    end

    assign w_err = (w_rd & w_wr)
                 | (w_is_half & (w_off == 2'd3))
                 | (w_is_word & (w_off != 2'd0))
                 | (w_rd & ((w_op == 3'b011) | (w_op == 3'b110) | (w_op == 3'b111)));

    // Shift-down word is trimmed and sign/zero-extended according to the load op.
    always_comb begin
        w_fmt = '0;
        case (w_op)
            3'b000:  w_fmt = {{24{w_rword[7]}},  w_rword[7:0]};
            3'b001:  w_fmt = {{16{w_rword[15]}}, w_rword[15:0]};
            3'b010:  w_fmt = w_rword;
            3'b100:  w_fmt = {24'd0, w_rword[7:0]};
            3'b101:  w_fmt = {16'd0, w_rword[15:0]};
            default: w_fmt = '0;
        endcase
    end

    // Next-state, wait counter and request acceptance.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_accept   = 1'b0;
        busy_o     = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy_o = req_rd_i | req_wr_i;
                if (req_rd_i | req_wr_i) begin
                    w_accept = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        w_next     = S_WAIT;
                        w_cnt_next = WAIT_INIT;
                    end else begin
                        w_next = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                busy_o = 1'b1;
                if (r_cnt == 4'd0) w_next = S_RESP;
                else               w_cnt_next = r_cnt - 4'd1;
            end
            S_RESP:  w_next = stall_i ? S_HOLD : S_IDLE;
            S_HOLD:  if (!stall_i) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_enter_resp = (w_next == S_RESP);
    assign w_do_write   = rst_n & w_enter_resp & w_wr & ~w_err;

    // State, request capture and registered response; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_op    <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_rd    <= req_rd_i;
                r_wr    <= req_wr_i;
                r_addr  <= req_addr_i[ADDR_WIDTH+1:0];
                r_wdata <= req_wdata_i;
                r_be    <= req_be_i;
                r_op    <= req_load_op_i;
            end
            if (w_enter_resp) begin
                r_err   <= w_err;
                r_rdata <= (w_err | w_wr) ? '0 : w_fmt;
            end
        end
    end

    // Byte-lane RAM write on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            for (int i = 0; i < NB; i++) begin
                if (w_lanes[i]) r_mem[w_idx][8*i +: 8] <= w_wshift[8*i +: 8];
            end
        end
    end

    assign w_valid     = (r_state == S_RESP) | (r_state == S_HOLD);
    assign rsp_valid_o = w_valid;
    assign rsp_rdata_o = w_valid ? r_rdata : '0;
    assign rsp_err_o   = w_valid & r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Purpose : randomized + directed bench for data_mem_responder (one WAIT_CYCLES=1 and one =0 instance).
// Latency : expects first response 1+WAIT_CYCLES cycles after a request is presented in IDLE.
// Backpres: requester holds while busy_o is high; stall_i holds responses for a chosen number of cycles.
module tb_data_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rstn, rd, wr, stall, busy, vld, err;
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic [3:0]  be    [2];
    logic [2:0]  op    [2];

    data_mem_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_CYCLES(1)) u_dut0 (
        .clk(clk), .rst_n(rstn[0]), .req_rd_i(rd[0]), .req_wr_i(wr[0]), .req_addr_i(addr[0]),
        .req_wdata_i(wdata[0]), .req_be_i(be[0]), .req_load_op_i(op[0]), .stall_i(stall[0]),
        .busy_o(busy[0]), .rsp_valid_o(vld[0]), .rsp_rdata_o(rdata[0]), .rsp_err_o(err[0]));

    data_mem_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_CYCLES(0)) u_dut1 (
        .clk(clk), .rst_n(rstn[1]), .req_rd_i(rd[1]), .req_wr_i(wr[1]), .req_addr_i(addr[1]),
        .req_wdata_i(wdata[1]), .req_be_i(be[1]), .req_load_op_i(op[1]), .stall_i(stall[1]),
        .busy_o(busy[1]), .rsp_valid_o(vld[1]), .rsp_rdata_o(rdata[1]), .rsp_err_o(err[1]));

    typedef struct {
        int          d;
        logic        err;
        logic [31:0] rdata;
        int          due;
        int          len;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur [2];
    logic [7:0]  mb [2][64];     // byte-addressed reference memory (low 64 bytes)
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    logic        pvld [2];
    int          runlen [2];
    logic [2:0]  ops [8];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%h required=%h (t=%0t)", nm, act, req, $time);
    endtask

    function automatic int wait_of(input int d);
        return (d == 0) ? 1 : 0;
    endfunction

    // Issue one transaction: compute the expected response from the reference model,
    // then play the requester side of the busy/stall handshake.
    task automatic txn(input int d, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] b, input logic [2:0] o,
                       input int stall_cyc);
        exp_t e;
        int   n, off, base, bn;
        logic done;
        logic [31:0] rv;
        off  = int'(a[1:0]);
        base = int'(a[5:0]);
        if (w && !r) n = (b == 4'hF) ? 4 : (b == 4'h3) ? 2 : 1;
        else         n = (o[1:0] == 2'b00) ? 1 : (o[1:0] == 2'b01) ? 2 : 4;
        e.d   = d;
        e.err = (r && w) || (off + n > 4) || (r && (o == 3'd3 || o == 3'd6 || o == 3'd7));
        rv = 32'd0;
        if (!e.err && w) begin
            for (int i = 0; i < n; i++) mb[d][base + i] = wd[8*i +: 8];
        end
        if (!e.err && r) begin
            for (int i = 0; i < n; i++) rv = rv | (32'(mb[d][base + i]) << (8 * i));
            if (!o[2] && n == 1 && rv[7])  rv = rv | 32'hFFFF_FF00;
            if (!o[2] && n == 2 && rv[15]) rv = rv | 32'hFFFF_0000;
        end
        e.rdata = rv;
        e.due   = cyc + 1 + wait_of(d);
        e.len   = stall_cyc + 1;
        exp_q.push_back(e);

        rd[d] = r; wr[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b; op[d] = o;
        stall[d] = (stall_cyc > 0);
        bn = 0;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (busy[d]) bn++;
            else         done = 1'b1;
        end
        chk("busy_cycles", 32'(bn), 32'(1 + wait_of(d)));
        if (stall_cyc > 0) begin
            repeat (stall_cyc) @(posedge clk);
            #1 stall[d] = 1'b0;
        end
        @(posedge clk);
        #1;
        rd[d] = 1'b0; wr[d] = 1'b0;
    endtask

    // Monitor: pop on the first valid cycle, check held data and hold length thereafter.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (vld[d]) begin
                if (!pvld[d]) begin
                    runlen[d] = 1;
                    if (exp_q.size() == 0 || exp_q[0].d != d) begin
                        chk("unexpected_rsp", {31'd0, vld[d]}, 32'd0);
                    end else begin
                        cur[d] = exp_q.pop_front();
                        chk("rsp_cycle", 32'(cyc), 32'(cur[d].due));
                        chk("rsp_err",   {31'd0, err[d]}, {31'd0, cur[d].err});
                        chk("rsp_rdata", rdata[d], cur[d].rdata);
                    end
                end else begin
                    runlen[d]++;
                    chk("held_rdata", rdata[d], cur[d].rdata);
                    chk("held_err",   {31'd0, err[d]}, {31'd0, cur[d].err});
                end
            end else begin
                chk("idle_zero", {rdata[d][30:0], err[d]}, 32'd0);
                if (pvld[d]) chk("valid_len", 32'(runlen[d]), 32'(cur[d].len));
            end
            pvld[d] = vld[d];
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, sz, st, d;
        logic [31:0] a;
        logic [3:0]  b;
        ops = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
        pvld[0] = 1'b0; pvld[1] = 1'b0;
        runlen[0] = 0; runlen[1] = 0;
        rstn = 2'b00; rd = 2'b00; wr = 2'b00; stall = 2'b00;
        for (int i = 0; i < 2; i++) begin
            addr[i] = '0; wdata[i] = '0; be[i] = '0; op[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_busy",  {31'd0, busy[i]}, 32'd0);
            chk("reset_valid", {31'd0, vld[i]},  32'd0);
            chk("reset_rdata", rdata[i], 32'd0);
            chk("reset_err",   {31'd0, err[i]},  32'd0);
        end
        @(posedge clk);
        #1 rstn = 2'b11;

        // Fill the low 16 words of both RAMs so every later load is defined.
        for (int dd = 0; dd < 2; dd++)
            for (int w = 0; w < 16; w++)
                txn(dd, 1'b0, 1'b1, 32'(w * 4), $urandom(), 4'hF, 3'd2, 0);

        // Directed, WAIT_CYCLES=1
        txn(0, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 3'd2, 0);
        txn(0, 1, 0, 32'h10, 32'h0,        4'hF, 3'd2, 0);
        txn(0, 0, 1, 32'h13, 32'h80,       4'h1, 3'd2, 0);
        txn(0, 1, 0, 32'h13, 32'h0,        4'h1, 3'd0, 0);
        txn(0, 1, 0, 32'h13, 32'h0,        4'h1, 3'd4, 0);
        txn(0, 1, 0, 32'h10, 32'h0,        4'hF, 3'd2, 0);
        txn(0, 0, 1, 32'h12, 32'h8001,     4'h3, 3'd2, 0);
        txn(0, 1, 0, 32'h12, 32'h0,        4'h3, 3'd1, 0);
        txn(0, 1, 0, 32'h12, 32'h0,        4'h3, 3'd5, 0);
        txn(0, 1, 0, 32'h10, 32'h0,        4'hF, 3'd2, 0);
        txn(0, 0, 1, 32'h11, 32'h12345678, 4'hF, 3'd2, 0);
        txn(0, 1, 0, 32'h10, 32'h0,        4'hF, 3'd2, 0);
        txn(0, 1, 1, 32'h10, 32'hFFFFFFFF, 4'hF, 3'd2, 0);
        txn(0, 1, 0, 32'h10, 32'h0,        4'hF, 3'd6, 0);
        txn(0, 1, 0, 32'h10, 32'h0,        4'hF, 3'd2, 3);

        // Reset during WAIT of a store: aborted, no write, no response.
        rd[0] = 0; wr[0] = 1; addr[0] = 32'h10; wdata[0] = 32'h12345678; be[0] = 4'hF; op[0] = 3'd2;
        @(posedge clk);
        #1 rstn[0] = 1'b0;
        @(posedge clk);
        #1;
        wr[0] = 1'b0; rstn[0] = 1'b1;
        @(negedge clk);
        chk("abort_busy",  {31'd0, busy[0]}, 32'd0);
        chk("abort_valid", {31'd0, vld[0]},  32'd0);
        @(posedge clk);
        #1;
        txn(0, 1, 0, 32'h10, 32'h0, 4'hF, 3'd2, 0);

        // Directed, WAIT_CYCLES=0: back-to-back and address aliasing.
        txn(1, 0, 1, 32'h20,   32'hCAFEF00D, 4'hF, 3'd2, 0);
        txn(1, 1, 0, 32'h20,   32'h0,        4'hF, 3'd2, 0);
        txn(1, 0, 1, 32'h1010, 32'hA5A55A5A, 4'hF, 3'd2, 0);
        txn(1, 1, 0, 32'h0010, 32'h0,        4'hF, 3'd2, 0);

        // Randomized mix over both instances.
        for (int i = 0; i < 200; i++) begin
            d  = int'($urandom_range(0, 1));
            k  = int'($urandom_range(0, 19));
            a  = ($urandom() & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            if (k < 7) begin
                sz = int'($urandom_range(0, 2));
                b  = (sz == 0) ? 4'h1 : (sz == 1) ? 4'h3 : 4'hF;
                txn(d, 0, 1, a, $urandom(), b, 3'd2, st);
            end else if (k < 18) begin
                txn(d, 1, 0, a, 32'h0, 4'hF,
                    ops[(k == 17) ? $urandom_range(5, 7) : $urandom_range(0, 4)], st);
            end else begin
                txn(d, 1, 1, a, $urandom(), 4'hF, 3'd2, st);
            end
        end

        repeat (5) @(posedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
